// File: rtl/rr_ingress_queue.sv
// Per-channel ingress FIFOs feeding a round-robin arbiter; pops the granted
// channel and forwards its head word, tagged with the channel index, downstream.
module rr_ingress_queue #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*DW-1:0]      in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         grant,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(N_CH)-1:0] out_ch,
    output logic                    err
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CHW = $clog2(N_CH);

    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    logic [N_CH-1:0] nonempty;
    logic [DW-1:0]   head_w [N_CH];
    logic [CHW-1:0]  gidx;
    logic            grant_onehot;
    logic            grant_ok;
    logic            grant_bad;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [CHW-1:0]  out_ch_q, out_ch_d;
    logic            err_q, err_d;

    // A grant is only honoured when it is one-hot and hits a channel with data.
    always_comb begin
        grant_onehot = (grant != '0) && ((grant & (grant - N_CH'(1))) == '0);
        grant_ok     = grant_onehot && ((grant & nonempty) != '0);
        grant_bad    = (grant != '0) && !grant_ok;
        gidx         = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                gidx = CHW'(i);
            end
        end
    end

    assign push = in_valid & in_ready;
    assign pop  = grant & {N_CH{grant_ok}};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [DW-1:0] mem_q [DEPTH];

        always_comb begin
            cnt_d    = cnt_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (push[g]) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop[g]) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push[g] && !pop[g]) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push[g] && pop[g]) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                cnt_q    <= cnt_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // Storage needs no reset: occupancy alone defines which entries are live.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= in_data[g*DW +: DW];
            end
        end

        // Ready comes from the registered count, so a same-cycle pop never frees a slot.
        assign in_ready[g] = (cnt_q != CW'(DEPTH));
        assign nonempty[g] = (cnt_q != '0);
        assign req[g]      = ((cnt_q - CW'(pop[g])) != '0);
        assign head_w[g]   = mem_q[rd_ptr_q];
    end

    always_comb begin
        out_valid_d = grant_ok;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        err_d       = err_q | grant_bad;
        if (grant_ok) begin
            out_data_d = head_w[gidx];
            out_ch_d   = gidx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign err       = err_q;

endmodule
